// File: rtl/cpu_sequencer.sv
// cpu_sequencer: autonomous front-end controller for the CPU block.
// Holds an 8-entry preload table and a small instruction program. On start it
// walks the preload table in load mode (LO=0), then issues the program one
// instruction per cycle in operate mode (LO=1), and watches the CPU OV flag.
//
// Optional feature: define SEQ_OV_ABORT_EN to end the execute phase early
// when OV is seen; otherwise OV only sets the sticky ov_err flag.
//
// Every CPU-facing output is a register fed from the decoded FSM state, so the
// outputs trail the internal state by one cycle. This is what places the first
// load cycle at start+1 and done at start+8+len+1.
module cpu_sequencer #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_wdata,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              pre_we,
    input  logic [2:0]        pre_sel,
    input  logic [31:0]       pre_wdata,
    input  logic              pre_clr,
    input  logic              OV,
    output logic [31:0]       INS,
    output logic [31:0]       ManIn,
    output logic [2:0]        RSM,
    output logic              WR,
    output logic              LO,
    output logic              busy,
    output logic              done,
    output logic              ov_err,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    // Largest usable instruction count (2**ADDR_W) and unit constants sized to match.
    localparam logic [ADDR_W:0]   LenMax = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LenOne = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] KOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [Depth];
    logic [31:0]       r_pre [8];
    logic [7:0]        r_valid;

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_sel;
    logic [2:0]        w_sel_next;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] w_k_next;
    logic [ADDR_W:0]   r_len;

    // ------------------------------------------------------------------
    // Output registers and their next values
    // ------------------------------------------------------------------
    logic [31:0]       r_ins;
    logic [31:0]       r_manin;
    logic [2:0]        r_rsm;
    logic              r_wr;
    logic              r_lo;
    logic              r_busy;
    logic              r_done;
    logic              r_ov_err;
    logic [ADDR_W-1:0] r_pc;

    logic [31:0]       w_ins;
    logic [31:0]       w_manin;
    logic [2:0]        w_rsm;
    logic              w_wr;
    logic              w_lo;
    logic              w_busy;
    logic              w_done;
    logic [ADDR_W-1:0] w_pc;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_accept;
    logic w_cfg_ok;
    logic w_last_exec;
    logic w_abort;

    // Fully idle only once the registered busy has dropped too, so the visible
    // DONE cycle still counts as busy for start and configuration writes.
    assign w_idle      = (r_state == StIdle) && !r_busy;
    assign w_accept    = w_idle && start;
    // Configuration writes are dropped while busy and on the cycle of an accepted start.
    assign w_cfg_ok    = w_idle && !start;
    assign w_last_exec = ({1'b0, r_k} == (r_len - LenOne));

`ifdef SEQ_OV_ABORT_EN
    // r_wr && r_lo is only true while an EXEC cycle is on the pins.
    assign w_abort = r_wr && r_lo && OV;
`else
    assign w_abort = 1'b0;
`endif

    // Program and preload data memories; not reset.
    always_ff @(posedge clk) begin
        if (w_cfg_ok && prog_we) begin
            r_mem[prog_addr] <= prog_wdata;
        end
        if (w_cfg_ok && pre_we) begin
            r_pre[pre_sel] <= pre_wdata;
        end
    end

    // Preload valid bits; a clear takes priority over a same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_cfg_ok) begin
            if (pre_clr) begin
                r_valid <= '0;
            end else if (pre_we) begin
                r_valid[pre_sel] <= 1'b1;
            end
        end
    end

    // FSM state register with load/exec counters and the latched length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_k     <= '0;
            r_len   <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_k     <= w_k_next;
            if (w_accept) begin
                r_len <= (prog_len > LenMax) ? LenMax : prog_len;
            end
        end
    end

    // FSM next-state logic: IDLE -> LOAD (8 cycles) -> EXEC (len cycles) -> DONE -> IDLE.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_k_next     = r_k;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StLoad;
                    w_sel_next   = '0;
                end
            end
            StLoad: begin
                w_sel_next = r_sel + 3'd1;
                if (r_sel == 3'd7) begin
                    w_k_next     = '0;
                    w_state_next = (r_len == '0) ? StDone : StExec;
                end
            end
            StExec: begin
                if (w_last_exec) begin
                    w_state_next = StDone;
                end else begin
                    w_k_next = r_k + KOne;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // An abort shows DONE on the pins next cycle, so the FSM itself goes to IDLE.
        if (w_abort) begin
            w_state_next = StIdle;
        end
    end

    // FSM output decode; values land on the pins one cycle later.
    always_comb begin
        w_ins   = '0;
        w_manin = '0;
        w_rsm   = '0;
        w_wr    = 1'b0;
        w_lo    = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_pc    = '0;
        unique case (r_state)
            StIdle: begin
                w_busy = 1'b0;
            end
            StLoad: begin
                w_busy  = 1'b1;
                w_rsm   = r_sel;
                w_manin = r_pre[r_sel];
                w_wr    = r_valid[r_sel];
            end
            StExec: begin
                w_busy = 1'b1;
                w_lo   = 1'b1;
                w_wr   = 1'b1;
                w_ins  = r_mem[r_k];
                w_pc   = r_k;
            end
            StDone: begin
                w_busy = 1'b1;
                w_lo   = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
        if (w_abort) begin
            w_ins   = '0;
            w_manin = '0;
            w_rsm   = '0;
            w_wr    = 1'b0;
            w_pc    = '0;
            w_lo    = 1'b1;
            w_busy  = 1'b1;
            w_done  = 1'b1;
        end
    end

    // Output registers; ov_err samples OV whenever LO=1 (EXEC and DONE on the pins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ins    <= '0;
            r_manin  <= '0;
            r_rsm    <= '0;
            r_wr     <= 1'b0;
            r_lo     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pc     <= '0;
            r_ov_err <= 1'b0;
        end else begin
            r_ins   <= w_ins;
            r_manin <= w_manin;
            r_rsm   <= w_rsm;
            r_wr    <= w_wr;
            r_lo    <= w_lo;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pc    <= w_pc;
            if (w_accept) begin
                r_ov_err <= 1'b0;
            end else if (r_lo && OV) begin
                r_ov_err <= 1'b1;
            end
        end
    end

    assign INS    = r_ins;
    assign ManIn  = r_manin;
    assign RSM    = r_rsm;
    assign WR     = r_wr;
    assign LO     = r_lo;
    assign busy   = r_busy;
    assign done   = r_done;
    assign ov_err = r_ov_err;
    assign pc     = r_pc;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table of sequencer runs; each run pushes its expected
// per-cycle pin trace to a queue when start is driven, and the trace is popped
// and compared one record per cycle. Hand-written runs cover start/prog_we
// while busy and reset in the middle of EXEC.
module tb_cpu_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic [4:0]  prog_len;
    logic        pre_we;
    logic [2:0]  pre_sel;
    logic [31:0] pre_wdata;
    logic        pre_clr;
    logic        OV;
    logic [31:0] INS;
    logic [31:0] ManIn;
    logic [2:0]  RSM;
    logic        WR;
    logic        LO;
    logic        busy;
    logic        done;
    logic        ov_err;
    logic [3:0]  pc;

    cpu_sequencer #(.ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .prog_len  (prog_len),
        .pre_we    (pre_we),
        .pre_sel   (pre_sel),
        .pre_wdata (pre_wdata),
        .pre_clr   (pre_clr),
        .OV        (OV),
        .INS       (INS),
        .ManIn     (ManIn),
        .RSM       (RSM),
        .WR        (WR),
        .LO        (LO),
        .busy      (busy),
        .done      (done),
        .ov_err    (ov_err),
        .pc        (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0][31:0]  pre;
        logic [15:0][31:0] prog;
        int                plen;
        logic [7:0]        mask;
        int                ov_k;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        lo;
        logic [2:0]  rsm;
        logic [31:0] manin;
        logic [31:0] ins;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
        logic        ov_err;
    } rec_t;

    vec_t        vecs[6];
    rec_t        exp_q[$];
    logic [31:0] tb_pre[8];
    logic [31:0] tb_mem[16];
    logic [7:0]  tb_valid;
    int          n_checks;
    int          n_fail;

    function automatic rec_t zrec(input logic ov);
        rec_t r;
        r.wr = 0; r.lo = 0; r.rsm = 0; r.manin = 0; r.ins = 0; r.pc = 0;
        r.busy = 0; r.done = 0; r.ov_err = ov;
        return r;
    endfunction

    task automatic check(input rec_t e, input string name);
        n_checks++;
        if (WR !== e.wr || LO !== e.lo || RSM !== e.rsm || ManIn !== e.manin || INS !== e.ins ||
            pc !== e.pc || busy !== e.busy || done !== e.done || ov_err !== e.ov_err) begin
            n_fail++;
            $display("FAIL %s: got wr=%0b lo=%0b rsm=%0d manin=%h ins=%h pc=%0d busy=%0b done=%0b ov_err=%0b; want wr=%0b lo=%0b rsm=%0d manin=%h ins=%h pc=%0d busy=%0b done=%0b ov_err=%0b",
                     name, WR, LO, RSM, ManIn, INS, pc, busy, done, ov_err,
                     e.wr, e.lo, e.rsm, e.manin, e.ins, e.pc, e.busy, e.done, e.ov_err);
        end
    endtask

    task automatic write_prog(input int a, input logic [31:0] d);
        @(negedge clk);
        prog_we = 1; prog_addr = 4'(a); prog_wdata = d;
        @(negedge clk);
        prog_we = 0;
        tb_mem[a] = d;
    endtask

    task automatic write_pre(input int s, input logic [31:0] d, input logic clr);
        @(negedge clk);
        pre_we = 1; pre_sel = 3'(s); pre_wdata = d; pre_clr = clr;
        @(negedge clk);
        pre_we = 0; pre_clr = 0;
        tb_pre[s] = d;
        if (clr) tb_valid = '0;
        else     tb_valid[s] = 1'b1;
    endtask

    task automatic setup_vec(input vec_t v);
        int le;
        le = (v.plen > 16) ? 16 : v.plen;
        for (int k = 0; k < le; k++) write_prog(k, v.prog[k]);
        for (int s = 0; s < 8; s++) write_pre(s, v.pre[s], 1'b0);
        // Clear and write together: the clear must win, leaving no valid bits.
        write_pre(7, v.pre[7], 1'b1);
        for (int s = 0; s < 8; s++) if (v.mask[s]) write_pre(s, v.pre[s], 1'b0);
    endtask

    // Runs one sequence. inj_* give the record index after which start, prog_we
    // or reset is driven (-1 = never).
    task automatic run_seq(input int idx, input bit setup, input int inj_start,
                           input int inj_pwe, input int inj_rst);
        vec_t v;
        rec_t r;
        int   le;
        int   n_iss;
        bit   ov_hit;
        v = vecs[idx];
        if (setup) setup_vec(v);
        le     = (v.plen > 16) ? 16 : v.plen;
        n_iss  = le;
        ov_hit = (v.ov_k >= 0) && (v.ov_k < le);
`ifdef SEQ_OV_ABORT_EN
        if (ov_hit) n_iss = v.ov_k + 1;
`endif
        @(negedge clk);
        start = 1; prog_len = 5'(v.plen);
        // Expected trace, one record per cycle from the start edge on.
        exp_q.push_back(zrec(1'b0));
        for (int s = 0; s < 8; s++) begin
            r = zrec(1'b0);
            r.busy = 1; r.rsm = 3'(s); r.manin = tb_pre[s]; r.wr = tb_valid[s];
            exp_q.push_back(r);
        end
        for (int k = 0; k < n_iss; k++) begin
            r = zrec(ov_hit && (k > v.ov_k));
            r.busy = 1; r.lo = 1; r.wr = 1; r.ins = tb_mem[k]; r.pc = 4'(k);
            exp_q.push_back(r);
        end
        r = zrec(ov_hit);
        r.busy = 1; r.lo = 1; r.done = 1;
        exp_q.push_back(r);
        exp_q.push_back(zrec(ov_hit));
        if (inj_start >= 0) repeat (3) exp_q.push_back(zrec(ov_hit));

        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            start = 0; prog_we = 0;
            r = exp_q.pop_front();
            check(r, $sformatf("vec%0d_cyc%0d", idx, i));
            OV = ov_hit && (i == 9 + v.ov_k);
            if (i == inj_start) start = 1;
            if (i == inj_pwe) begin
                prog_we = 1; prog_addr = 0; prog_wdata = ~tb_mem[0];
            end
            if (i == inj_rst) begin
                OV = 0;
                reset = 1;
                #1;
                check(zrec(1'b0), $sformatf("vec%0d_rst_async", idx));
                @(negedge clk);
                check(zrec(1'b0), $sformatf("vec%0d_rst_held", idx));
                reset = 0;
                tb_valid = '0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check(zrec(1'b0), $sformatf("vec%0d_rst_nodone%0d", idx, j));
                end
                exp_q.delete();
                break;
            end
        end
        OV = 0; start = 0; prog_we = 0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1; start = 0; prog_we = 0; prog_addr = 0; prog_wdata = 0; prog_len = 0;
        pre_we = 0; pre_sel = 0; pre_wdata = 0; pre_clr = 0; OV = 0;
        tb_valid = '0;
        for (int s = 0; s < 8; s++) tb_pre[s] = 0;
        for (int k = 0; k < 16; k++) tb_mem[k] = 0;

        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < 8; s++) vecs[v].pre[s] = 32'h1000_0000 * v + 32'h11 * s + 1;
            for (int k = 0; k < 16; k++) vecs[v].prog[k] = 32'hC000_0000 | (v << 16) | (k + 1);
            vecs[v].ov_k = -1;
        end
        // Swap r0/r1 through add/sub.
        vecs[0].pre[0] = 51; vecs[0].pre[1] = 32;
        vecs[0].prog[0] = 32'h0001_0000; vecs[0].prog[1] = 32'h1001_0800;
        vecs[0].prog[2] = 32'h1001_0000;
        vecs[0].plen = 3;  vecs[0].mask = 8'h03;
        vecs[1].pre[2] = 7;
        vecs[1].plen = 0;  vecs[1].mask = 8'h04;
        vecs[2].plen = 4;  vecs[2].mask = 8'hFF; vecs[2].ov_k = 1;
        vecs[3].plen = 31; vecs[3].mask = 8'h81;
        vecs[4].plen = 1;  vecs[4].mask = 8'h00; vecs[4].ov_k = 0;
        vecs[5].plen = 16; vecs[5].mask = 8'h5A;

        @(negedge clk);
        check(zrec(1'b0), "reset_state");
        reset = 0;
        @(negedge clk);
        check(zrec(1'b0), "after_reset_idle");

        for (int v = 0; v < 6; v++) run_seq(v, 1'b1, -1, -1, -1);

        // start at start+3 and prog_we at start+5 while busy: both ignored.
        run_seq(0, 1'b1, 2, 4, -1);
        // Reset during EXEC k=2.
        run_seq(5, 1'b1, -1, -1, 11);
        // Valid bits were cleared by reset: no WR during LOAD.
        run_seq(1, 1'b0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
